// File: rtl/sdram_func_module.sv
// rtl/sdram_func_module.sv - SDRAM write/read/refresh command sequencer.
// Optional byte mask: SDRAM_FUNC_BYTE_MASK_EN.
module sdram_func_module #(
    parameter int TRCD = 2,
    parameter int CL   = 2,
    parameter int TWR  = 2,
    parameter int TRP  = 2,
    parameter int TRFC = 6
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  Func_Start_Sig,
    input  logic [23:0] Addr,
    input  logic [15:0] WrData,
`ifdef SDRAM_FUNC_BYTE_MASK_EN
    input  logic [1:0]  WrMask,
    output logic [1:0]  SDRAM_DQM,
`endif
    output logic [15:0] RdData,
    output logic        RdData_Valid,
    output logic        Func_Done_Sig,
    output logic [3:0]  SDRAM_CMD,
    output logic [1:0]  SDRAM_BA,
    output logic [12:0] SDRAM_A,
    output logic [15:0] SDRAM_DQ_Out,
    output logic        SDRAM_DQ_OE,
    input  logic [15:0] SDRAM_DQ_In
);
    localparam int CW = 5;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [CW-1:0] WR_LAST = CW'(TRCD + TWR + TRP);
    localparam logic [CW-1:0] RD_LAST = CW'(TRCD + CL + 1);
    localparam logic [CW-1:0] RF_LAST = CW'(TRP + TRFC);
    localparam logic [CW-1:0] RD_CAP  = CW'(TRCD + CL);
    localparam logic [CW-1:0] C_TRCD  = CW'(TRCD);
    localparam logic [CW-1:0] C_TRP   = CW'(TRP);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RF} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, nxt, last;
    logic [2:0]    start_prev_q, start_prev_d, rise;
    logic [1:0]    bank_q, bank_d;
    logic [8:0]    col_q, col_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [1:0]    ba_q, ba_d;
    logic [12:0]   a_q, a_d;
    logic [15:0]   dq_out_q, dq_out_d;
    logic          dq_oe_q, dq_oe_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          done_q, done_d;
`ifdef SDRAM_FUNC_BYTE_MASK_EN
    logic [1:0]    mask_q, mask_d, dqm_q, dqm_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_prev_d = Func_Start_Sig;
        bank_d       = bank_q;
        col_d        = col_q;
        wdata_d      = wdata_q;
        cmd_d        = CMD_NOP;
        ba_d         = '0;
        a_d          = '0;
        dq_out_d     = '0;
        dq_oe_d      = 1'b0;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        done_d       = 1'b0;
`ifdef SDRAM_FUNC_BYTE_MASK_EN
        mask_d       = mask_q;
        dqm_d        = 2'b00;
`endif
        rise = Func_Start_Sig & ~start_prev_q;
        nxt  = cnt_q + 1'b1;
        last = (state_q == S_WR) ? WR_LAST : (state_q == S_RD) ? RD_LAST : RF_LAST;

        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (rise != 3'b000) begin
                bank_d  = Addr[23:22];
                col_d   = Addr[8:0];
                wdata_d = WrData;
`ifdef SDRAM_FUNC_BYTE_MASK_EN
                mask_d  = WrMask;
`endif
            end
            // Refresh wins over read, read over write; losing edges are dropped.
            if (rise[2]) begin
                state_d  = S_RF;
                cmd_d    = CMD_PRE;
                a_d[10]  = 1'b1;
            end else if (rise[1] || rise[0]) begin
                state_d = rise[1] ? S_RD : S_WR;
                cmd_d   = CMD_ACT;
                ba_d    = Addr[23:22];
                a_d     = Addr[21:9];
            end
        end else if (cnt_q == last) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d  = nxt;
            done_d = (nxt == last);
            if (state_q == S_RF) begin
                if (nxt == C_TRP) cmd_d = CMD_REF;
            end else if (nxt == C_TRCD) begin
                cmd_d = (state_q == S_WR) ? CMD_WRITE : CMD_READ;
                ba_d  = bank_q;
                a_d   = {2'b00, 1'b1, 1'b0, col_q};
                if (state_q == S_WR) begin
                    dq_oe_d  = 1'b1;
                    dq_out_d = wdata_q;
`ifdef SDRAM_FUNC_BYTE_MASK_EN
                    dqm_d    = mask_q;
`endif
                end
            end
            if (state_q == S_RD && cnt_q == RD_CAP) begin
                rd_data_d  = SDRAM_DQ_In;
                rd_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            start_prev_q <= '0;
            bank_q       <= '0;
            col_q        <= '0;
            wdata_q      <= '0;
            cmd_q        <= CMD_NOP;
            ba_q         <= '0;
            a_q          <= '0;
            dq_out_q     <= '0;
            dq_oe_q      <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            done_q       <= 1'b0;
`ifdef SDRAM_FUNC_BYTE_MASK_EN
            mask_q       <= 2'b00;
            dqm_q        <= 2'b00;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_prev_q <= start_prev_d;
            bank_q       <= bank_d;
            col_q        <= col_d;
            wdata_q      <= wdata_d;
            cmd_q        <= cmd_d;
            ba_q         <= ba_d;
            a_q          <= a_d;
            dq_out_q     <= dq_out_d;
            dq_oe_q      <= dq_oe_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            done_q       <= done_d;
`ifdef SDRAM_FUNC_BYTE_MASK_EN
            mask_q       <= mask_d;
            dqm_q        <= dqm_d;
`endif
        end
    end

    assign SDRAM_CMD     = cmd_q;
    assign SDRAM_BA      = ba_q;
    assign SDRAM_A       = a_q;
    assign SDRAM_DQ_Out  = dq_out_q;
    assign SDRAM_DQ_OE   = dq_oe_q;
    assign RdData        = rd_data_q;
    assign RdData_Valid  = rd_valid_q;
    assign Func_Done_Sig = done_q;
`ifdef SDRAM_FUNC_BYTE_MASK_EN
    assign SDRAM_DQM     = dqm_q;
`endif
endmodule
